// File: rtl/regfile_param.sv
// ----------------------------------------------------------------------------
// regfile_param
//
// Parameterised multi-read, single-write register file with an optional
// hard-wired zero register, optional same-cycle write-to-read forwarding and
// a background clear sweep that zeroes one register per cycle.
//
// Parameters
//   XLEN     register width in bits
//   NREGS    number of registers (need not be a power of two)
//   NREAD    number of combinational read ports
//   BYPASS   1 = an accepted write is forwarded to matching read ports
//   ZERO_REG 1 = register 0 always reads zero and ignores writes
//
// Ports
//   clock     single clock, all state changes on the rising edge
//   reset     synchronous, active-low
//   rd_addr   packed read addresses, port k at [k*AW +: AW]
//   rd_data   packed read data, port k at [k*XLEN +: XLEN]
//   wr_valid  write request
//   wr_ready  high when a write can be accepted (low during a sweep)
//   wr_addr   write address
//   wr_data   write data
//   clear     one-cycle pulse that starts the clear sweep
//   busy      high while the clear sweep runs
// ----------------------------------------------------------------------------
module regfile_param #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  clear,
  output logic                  busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   ptr;
  logic [XLEN-1:0] regs [NREGS];
  logic            wr_fire;
  logic            wr_effective;
  logic            sweep_last;

  // An address field may be wider than the register count needs when NREGS
  // is not a power of two; anything past the last register is treated as
  // unmapped on both the read and write side.
  function automatic logic addr_in_range(input logic [AW-1:0] a);
    return int'(a) < NREGS;
  endfunction

  // Register 0 is only special when the zero-register option is enabled.
  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wr_fire      = wr_valid && wr_ready;
  assign wr_effective = wr_fire && addr_in_range(wr_addr) && !is_zero_reg(wr_addr);
  assign sweep_last   = (ptr == AW'(NREGS - 1));

  // State register. Reset wins over everything and drops any sweep in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A clear pulse that arrives while already sweeping is
  // dropped; the sweep ends on the cycle that zeroes the last register.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clear) state_next = SWEEP;
      SWEEP:   if (sweep_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic. Writes are refused for the whole sweep so the sweep and
  // a normal write never compete for the storage.
  always_comb begin
    busy     = (state == SWEEP);
    wr_ready = !busy;
  end

  // Sweep pointer and storage. During a sweep one register is zeroed per
  // cycle. A write accepted in the same IDLE cycle as the clear pulse still
  // lands, and is then wiped by the sweep that follows.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (state == SWEEP) begin
      regs[ptr] <= '0;
      ptr       <= sweep_last ? '0 : ptr + AW'(1);
    end else begin
      ptr <= '0;
      if (wr_effective) begin
        regs[wr_addr] <= wr_data;
      end
    end
  end

  // Read ports. Priority: sweep in progress, then unmapped / zero register,
  // then forwarding of an accepted write, then the stored value.
  for (genvar k = 0; k < NREAD; k++) begin : g_read
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rv;

    assign ra = rd_addr[k*AW +: AW];

    always_comb begin
      rv = '0;
      if (!busy && addr_in_range(ra) && !is_zero_reg(ra)) begin
        if ((BYPASS != 0) && wr_fire && (wr_addr == ra)) begin
          rv = wr_data;
        end else begin
          rv = regs[ra];
        end
      end
    end

    assign rd_data[k*XLEN +: XLEN] = rv;
  end

endmodule
